// File: rtl/apmu_ibex_multdiv_issue.sv
// Issue/response wrapper around an Ibex-style slow multiplier/divider: holds operands stable for
// the slow unit, buffers its result for a valid/ready response, and provides the ALU adder service.
// Optional perf counters are compiled in with `define APMU_MD_PERF_EN.
module apmu_ibex_multdiv_issue (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [1:0]  req_signed_mode_i,
    input  logic [31:0] req_op_a_i,
    input  logic [31:0] req_op_b_i,
    input  logic        req_dit_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    input  logic        flush_i,
    output logic        mult_en_o,
    output logic        div_en_o,
    output logic        mult_sel_o,
    output logic        div_sel_o,
    output logic [1:0]  operator_o,
    output logic [1:0]  signed_mode_o,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    output logic        data_ind_timing_o,
    output logic        multdiv_ready_id_o,
    input  logic [32:0] alu_operand_a_i,
    input  logic [32:0] alu_operand_b_i,
    output logic [33:0] alu_adder_ext_o,
    output logic [31:0] alu_adder_o,
    output logic        equal_to_zero_o,
    input  logic [33:0] imd_val_d_i [2],
    input  logic [1:0]  imd_val_we_i,
    output logic [33:0] imd_val_q_o [2],
    input  logic        valid_i,
    input  logic [31:0] multdiv_result_i,
    output logic [15:0] perf_last_cycles_o,
    output logic [15:0] perf_op_count_o
);

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      r_state;
    md_op_e      r_op;
    logic [1:0]  r_signed_mode;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic        r_dit;
    logic [31:0] r_result;
    logic        r_flush_pend;
    logic [33:0] r_imd [2];

    logic        w_accept;
    logic        w_busy;
    logic        w_is_mult;
    logic        w_is_div;
    logic        w_drop_result;
    logic [33:0] w_adder_ext;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high; valid holds
    // its payload until that cycle. RESP can hand back a result and take the next request together.
    assign req_ready_o = (r_state == S_IDLE) | ((r_state == S_RESP) & rsp_ready_i);
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_busy      = (r_state == S_BUSY);

    assign w_is_mult     = (r_op == MD_OP_MULL) | (r_op == MD_OP_MULH);
    assign w_is_div      = (r_op == MD_OP_DIV)  | (r_op == MD_OP_REM);
    assign w_drop_result = r_flush_pend | flush_i;

    assign mult_en_o          = w_busy & w_is_mult;
    assign mult_sel_o         = w_busy & w_is_mult;
    assign div_en_o           = w_busy & w_is_div;
    assign div_sel_o          = w_busy & w_is_div;
    assign multdiv_ready_id_o = w_busy;

    assign operator_o        = r_op;
    assign signed_mode_o     = r_signed_mode;
    assign op_a_o            = r_op_a;
    assign op_b_o            = r_op_b;
    assign data_ind_timing_o = r_dit;

    assign rsp_valid_o  = (r_state == S_RESP);
    assign rsp_result_o = r_result;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_op          <= MD_OP_MULL;
            r_signed_mode <= 2'b00;
            r_op_a        <= 32'h0;
            r_op_b        <= 32'h0;
            r_dit         <= 1'b0;
            r_result      <= 32'h0;
            r_flush_pend  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op          <= md_op_e'(req_op_i);
                r_signed_mode <= req_signed_mode_i;
                r_op_a        <= req_op_a_i;
                r_op_b        <= req_op_b_i;
                r_dit         <= req_dit_i;
                r_flush_pend  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A flush only marks the result as unwanted; the slow unit still runs to valid_i.
                    if (flush_i) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (valid_i) begin
                        r_result <= multdiv_result_i;
                        r_state  <= w_drop_result ? S_IDLE : S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_accept) begin
                        r_state <= S_BUSY;
                    end else if (rsp_ready_i | flush_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Carry-out is kept in bit 33 so the extended sum never loses overflow.
    assign w_adder_ext     = {1'b0, alu_operand_a_i} + {1'b0, alu_operand_b_i};
    assign alu_adder_ext_o = w_adder_ext;
    assign alu_adder_o     = w_adder_ext[32:1];
    assign equal_to_zero_o = (w_adder_ext[32:1] == 32'h0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_imd[0] <= 34'h0;
            r_imd[1] <= 34'h0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (imd_val_we_i[i]) begin
                    r_imd[i] <= imd_val_d_i[i];
                end
            end
        end
    end

    assign imd_val_q_o[0] = r_imd[0];
    assign imd_val_q_o[1] = r_imd[1];

`ifdef APMU_MD_PERF_EN
    logic [15:0] r_busy_cnt;
    logic [15:0] r_last_cycles;
    logic [15:0] r_op_count;
    logic [15:0] w_busy_cnt_inc;

    assign w_busy_cnt_inc = (r_busy_cnt == 16'hFFFF) ? r_busy_cnt : r_busy_cnt + 16'd1;

    // r_busy_cnt holds the BUSY cycles already elapsed; the valid_i cycle itself adds one more.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_busy_cnt    <= 16'h0;
            r_last_cycles <= 16'h0;
            r_op_count    <= 16'h0;
        end else begin
            if (w_accept) begin
                r_busy_cnt <= 16'h0;
            end else if (w_busy) begin
                if (valid_i) begin
                    r_last_cycles <= w_busy_cnt_inc;
                    if (!w_drop_result) begin
                        r_op_count <= r_op_count + 16'd1;
                    end
                end else begin
                    r_busy_cnt <= w_busy_cnt_inc;
                end
            end
        end
    end

    assign perf_last_cycles_o = r_last_cycles;
    assign perf_op_count_o    = r_op_count;
`else
    assign perf_last_cycles_o = 16'h0;
    assign perf_op_count_o    = 16'h0;
`endif

endmodule

// File: tb/tb_apmu_ibex_multdiv_issue.sv
// Directed bench for apmu_ibex_multdiv_issue: the bench plays the slow mult/div unit and checks
// responses, control strobes, flush handling, ALU adder and intermediate storage against constants.
module tb_apmu_ibex_multdiv_issue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [1:0]  req_signed_mode_i;
    logic [31:0] req_op_a_i;
    logic [31:0] req_op_b_i;
    logic        req_dit_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        flush_i;
    logic        mult_en_o;
    logic        div_en_o;
    logic        mult_sel_o;
    logic        div_sel_o;
    logic [1:0]  operator_o;
    logic [1:0]  signed_mode_o;
    logic [31:0] op_a_o;
    logic [31:0] op_b_o;
    logic        data_ind_timing_o;
    logic        multdiv_ready_id_o;
    logic [32:0] alu_operand_a_i;
    logic [32:0] alu_operand_b_i;
    logic [33:0] alu_adder_ext_o;
    logic [31:0] alu_adder_o;
    logic        equal_to_zero_o;
    logic [33:0] imd_val_d_i [2];
    logic [1:0]  imd_val_we_i;
    logic [33:0] imd_val_q_o [2];
    logic        valid_i;
    logic [31:0] multdiv_result_i;
    logic [15:0] perf_last_cycles_o;
    logic [15:0] perf_op_count_o;

    apmu_ibex_multdiv_issue dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_op_i           (req_op_i),
        .req_signed_mode_i  (req_signed_mode_i),
        .req_op_a_i         (req_op_a_i),
        .req_op_b_i         (req_op_b_i),
        .req_dit_i          (req_dit_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_result_o       (rsp_result_o),
        .flush_i            (flush_i),
        .mult_en_o          (mult_en_o),
        .div_en_o           (div_en_o),
        .mult_sel_o         (mult_sel_o),
        .div_sel_o          (div_sel_o),
        .operator_o         (operator_o),
        .signed_mode_o      (signed_mode_o),
        .op_a_o             (op_a_o),
        .op_b_o             (op_b_o),
        .data_ind_timing_o  (data_ind_timing_o),
        .multdiv_ready_id_o (multdiv_ready_id_o),
        .alu_operand_a_i    (alu_operand_a_i),
        .alu_operand_b_i    (alu_operand_b_i),
        .alu_adder_ext_o    (alu_adder_ext_o),
        .alu_adder_o        (alu_adder_o),
        .equal_to_zero_o    (equal_to_zero_o),
        .imd_val_d_i        (imd_val_d_i),
        .imd_val_we_i       (imd_val_we_i),
        .imd_val_q_o        (imd_val_q_o),
        .valid_i            (valid_i),
        .multdiv_result_i   (multdiv_result_i),
        .perf_last_cycles_o (perf_last_cycles_o),
        .perf_op_count_o    (perf_op_count_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef APMU_MD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sm;
        logic [31:0] a;
        logic [31:0] b;
        logic        dit;
        int          lat;
        int          hold_c;
        logic [31:0] expv;
    } vec_t;

    vec_t        vecs [11];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_cnt = 16'h0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Behavioural slow unit: RISC-V mul/div semantics on what the DUT presents to it.
    function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [1:0] sm,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        logic [63:0] p;
        logic [31:0] r;
        xa = sm[0] ? {{32{a[31]}}, a} : {32'h0, a};
        xb = sm[1] ? {{32{b[31]}}, b} : {32'h0, b};
        p  = xa * xb;
        if (op == 2'd0) r = p[31:0];
        else if (op == 2'd1) r = p[63:32];
        else if (b == 32'h0) r = (op == 2'd2) ? 32'hFFFFFFFF : a;
        else if (sm != 2'b00 && a == 32'h80000000 && b == 32'hFFFFFFFF) r = (op == 2'd2) ? a : 32'h0;
        else if (sm != 2'b00) r = (op == 2'd2) ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
        else r = (op == 2'd2) ? a / b : a % b;
        return r;
    endfunction

    task automatic do_accept(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a,
                             input logic [31:0] b, input logic dit);
        req_valid_i       = 1'b1;
        req_op_i          = op;
        req_signed_mode_i = sm;
        req_op_a_i        = a;
        req_op_b_i        = b;
        req_dit_i         = dit;
        #1 check("accept_ready", 96'(req_ready_o), 96'(1'b1));
        tick();
        req_valid_i       = 1'b0;
        req_op_i          = 2'($urandom);
        req_signed_mode_i = 2'($urandom);
        req_op_a_i        = $urandom;
        req_op_b_i        = $urandom;
        req_dit_i         = 1'($urandom);
    endtask

    task automatic do_valid();
        valid_i          = 1'b1;
        multdiv_result_i = ref_md(operator_o, signed_mode_o, op_a_o, op_b_o);
        tick();
        valid_i          = 1'b0;
        multdiv_result_i = $urandom;
    endtask

    task automatic check_busy(input string name, input logic [1:0] op);
        logic m;
        m = (op == 2'd0) || (op == 2'd1);
        check(name, 96'({mult_en_o, mult_sel_o, div_en_o, div_sel_o, multdiv_ready_id_o,
                         req_ready_o, rsp_valid_o}),
              96'({m, m, !m, !m, 1'b1, 1'b0, 1'b0}));
    endtask

    task automatic check_perf(input string name, input int busy_cycles);
        logic [15:0] exp_last;
        exp_last = PERF ? 16'(busy_cycles) : 16'h0;
        check(name, 96'({perf_last_cycles_o, perf_op_count_o}), 96'({exp_last, exp_cnt}));
    endtask

    task automatic run_op(input vec_t v);
        do_accept(v.op, v.sm, v.a, v.b, v.dit);
        #1 check_busy("busy_ctrl", v.op);
        check("busy_ops", 96'({op_a_o, op_b_o, operator_o, signed_mode_o, data_ind_timing_o}),
              96'({v.a, v.b, v.op, v.sm, v.dit}));
        repeat (v.lat) tick();
        #1 check("busy_ops_hold", 96'({op_a_o, op_b_o, operator_o, signed_mode_o, data_ind_timing_o}),
                 96'({v.a, v.b, v.op, v.sm, v.dit}));
        do_valid();
        #1 check("rsp_out", 96'({rsp_valid_o, req_ready_o, multdiv_ready_id_o, rsp_result_o}),
                 96'({1'b1, 1'b0, 1'b0, v.expv}));
        for (int k = 0; k < v.hold_c; k++) begin
            tick();
            #1 check("rsp_hold", 96'({rsp_valid_o, req_ready_o, rsp_result_o}), 96'({1'b1, 1'b0, v.expv}));
        end
        rsp_ready_i = 1'b1;
        #1 check("rsp_ready_pass", 96'(req_ready_o), 96'(1'b1));
        tick();
        rsp_ready_i = 1'b0;
        if (PERF) exp_cnt = exp_cnt + 16'd1;
        #1 check("after_rsp", 96'({rsp_valid_o, req_ready_o}), 96'(2'b01));
        check_perf("perf_op", v.lat + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2'd0, 2'b00, 32'h00000007, 32'h00000006, 1'b0, 1, 0, 32'h0000002A};
        vecs[1]  = '{2'd2, 2'b11, 32'hFFFFFFF9, 32'h00000002, 1'b0, 3, 0, 32'hFFFFFFFD};
        vecs[2]  = '{2'd3, 2'b11, 32'hFFFFFFF9, 32'h00000002, 1'b0, 2, 1, 32'hFFFFFFFF};
        vecs[3]  = '{2'd2, 2'b11, 32'h00000005, 32'h00000000, 1'b0, 1, 0, 32'hFFFFFFFF};
        vecs[4]  = '{2'd3, 2'b11, 32'h00000005, 32'h00000000, 1'b1, 2, 0, 32'h00000005};
        vecs[5]  = '{2'd1, 2'b11, 32'h80000000, 32'h80000000, 1'b0, 4, 5, 32'h40000000};
        vecs[6]  = '{2'd1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 2, 0, 32'hFFFFFFFE};
        vecs[7]  = '{2'd0, 2'b00, 32'h12345678, 32'h00000001, 1'b0, 1, 0, 32'h12345678};
        vecs[8]  = '{2'd2, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 3, 0, 32'h80000000};
        vecs[9]  = '{2'd3, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1, 0, 32'h00000000};
        vecs[10] = '{2'd2, 2'b00, 32'hFFFFFFF9, 32'h00000002, 1'b0, 2, 2, 32'h7FFFFFFC};

        rst_ni = 1'b0; req_valid_i = 1'b0; req_op_i = 2'd0; req_signed_mode_i = 2'b00;
        req_op_a_i = 32'h0; req_op_b_i = 32'h0; req_dit_i = 1'b0; rsp_ready_i = 1'b0;
        flush_i = 1'b0; alu_operand_a_i = 33'h0; alu_operand_b_i = 33'h0;
        imd_val_d_i[0] = 34'h0; imd_val_d_i[1] = 34'h0; imd_val_we_i = 2'b00;
        valid_i = 1'b0; multdiv_result_i = 32'h0;

        // Reset state
        repeat (3) tick();
        #1 check("rst_ctrl", 96'({req_ready_o, rsp_valid_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o,
                                  multdiv_ready_id_o}), 96'(7'b1000000));
        check("rst_result", 96'(rsp_result_o), 96'(32'h0));
        check("rst_imd", 96'({imd_val_q_o[0], imd_val_q_o[1]}), 96'(68'h0));
        check("rst_perf", 96'({perf_last_cycles_o, perf_op_count_o}), 96'(32'h0));
        rst_ni = 1'b1;

        // ALU adder service
        alu_operand_a_i = 33'h1_FFFF_FFFF; alu_operand_b_i = 33'h0_0000_0001;
        #1 check("alu_carry", 96'({alu_adder_ext_o, alu_adder_o, equal_to_zero_o}),
                 96'({34'h2_0000_0000, 32'h0, 1'b1}));
        alu_operand_a_i = 33'h0_0000_0002; alu_operand_b_i = 33'h0_0000_0004;
        #1 check("alu_small", 96'({alu_adder_ext_o, alu_adder_o, equal_to_zero_o}),
                 96'({34'h0_0000_0006, 32'h3, 1'b0}));
        alu_operand_a_i = 33'h1_2345_6789; alu_operand_b_i = 33'h0_0000_0001;
        #1 check("alu_mid", 96'({alu_adder_ext_o, alu_adder_o, equal_to_zero_o}),
                 96'({34'h1_2345_678A, 32'h91A2B3C5, 1'b0}));

        // Intermediate storage: per-slot write enable, hold otherwise
        tick();
        imd_val_d_i[0] = 34'h2_1234_5678; imd_val_d_i[1] = 34'h1_ABCD_0000; imd_val_we_i = 2'b01;
        tick();
        imd_val_we_i = 2'b00;
        #1 check("imd_we0", 96'({imd_val_q_o[0], imd_val_q_o[1]}), 96'({34'h2_1234_5678, 34'h0}));
        imd_val_d_i[0] = 34'h0_0000_1111; imd_val_we_i = 2'b10;
        tick();
        imd_val_we_i = 2'b00;
        #1 check("imd_we1", 96'({imd_val_q_o[0], imd_val_q_o[1]}), 96'({34'h2_1234_5678, 34'h1_ABCD_0000}));
        imd_val_d_i[0] = 34'h3_FFFF_FFFF; imd_val_d_i[1] = 34'h3_FFFF_FFFF;
        tick();
        #1 check("imd_hold", 96'({imd_val_q_o[0], imd_val_q_o[1]}), 96'({34'h2_1234_5678, 34'h1_ABCD_0000}));

        // Table-driven operations
        for (int i = 0; i < 11; i++) run_op(vecs[i]);

        // Flush mid-DIV: slow unit keeps running, no response, op count untouched
        do_accept(2'd2, 2'b00, 32'd100, 32'd7, 1'b0);
        flush_i = 1'b1;
        #1 check_busy("flush_busy", 2'd2);
        tick();
        flush_i = 1'b0;
        #1 check_busy("flush_pend_busy", 2'd2);
        tick();
        do_valid();
        #1 check("flush_no_rsp", 96'({rsp_valid_o, req_ready_o, multdiv_ready_id_o}), 96'(3'b010));
        check_perf("flush_perf", 3);
        tick();
        #1 check("flush_stays_idle", 96'({rsp_valid_o, req_ready_o}), 96'(2'b01));
        run_op('{2'd0, 2'b00, 32'd3, 32'd3, 1'b0, 1, 0, 32'd9});

        // Flush in the same cycle as valid_i
        do_accept(2'd0, 2'b00, 32'd5, 32'd5, 1'b0);
        tick();
        flush_i = 1'b1;
        do_valid();
        flush_i = 1'b0;
        #1 check("flush_valid_no_rsp", 96'({rsp_valid_o, req_ready_o}), 96'(2'b01));
        check_perf("flush_valid_perf", 2);

        // Flush while a response waits: dropped without handshake
        do_accept(2'd0, 2'b00, 32'd2, 32'd2, 1'b0);
        tick();
        do_valid();
        if (PERF) exp_cnt = exp_cnt + 16'd1;
        #1 check("resp_before_flush", 96'({rsp_valid_o, rsp_result_o}), 96'({1'b1, 32'd4}));
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1 check("resp_flushed", 96'({rsp_valid_o, req_ready_o}), 96'(2'b01));

        // Back-to-back: response handshake and next request in the same cycle
        do_accept(2'd0, 2'b00, 32'd4, 32'd4, 1'b0);
        tick();
        do_valid();
        if (PERF) exp_cnt = exp_cnt + 16'd1;
        rsp_ready_i = 1'b1;
        do_accept(2'd3, 2'b00, 32'd17, 32'd5, 1'b1);
        rsp_ready_i = 1'b0;
        #1 check_busy("b2b_busy", 2'd3);
        check("b2b_ops", 96'({op_a_o, op_b_o, data_ind_timing_o}), 96'({32'd17, 32'd5, 1'b1}));
        tick();
        do_valid();
        if (PERF) exp_cnt = exp_cnt + 16'd1;
        #1 check("b2b_rsp", 96'({rsp_valid_o, rsp_result_o}), 96'({1'b1, 32'd2}));
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        #1 check_perf("b2b_perf", 2);

        // Reset in the middle of BUSY abandons the operation
        do_accept(2'd1, 2'b11, 32'h11111111, 32'h22222222, 1'b0);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        exp_cnt = 16'h0;
        #1 check("rst_busy_ctrl", 96'({req_ready_o, rsp_valid_o, mult_en_o, div_en_o, mult_sel_o,
                                       div_sel_o, multdiv_ready_id_o}), 96'(7'b1000000));
        check("rst_busy_regs", 96'({rsp_result_o, op_a_o, perf_last_cycles_o, perf_op_count_o}), 96'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
